// File: rtl/xcore_if_btb_sa.sv
// Set-associative BTB for the Xcore pre-IF/IF stage with tree-PLRU replacement.
// Define XCORE_BTB_FLUSH_EN to build the multi-cycle flush sweep FSM.
module xcore_if_btb_sa #(
  parameter int XLEN  = 32,
  parameter int SETS  = 64,
  parameter int WAYS  = 2,
  parameter int TAG_W = 16,
  parameter int TGT_W = 16,
  localparam int WB   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic            i_sys_clk,
  input  logic            i_sys_rst,
  input  logic [XLEN-1:0] i_pref_pc,
  input  logic [XLEN-1:0] i_bpu_instr_pc,
  input  logic            i_bpu_btb_update,
  input  logic [2:0]      i_bpu_btb_type,
  input  logic [XLEN-1:0] i_bpu_btb_target,
  input  logic            i_bpu_btb_valid,
  input  logic [XLEN-1:0] i_wb_instr_pc,
  input  logic            i_wb_cmt_req,
  input  logic [2:0]      i_wb_cmt_type,
  input  logic [XLEN-1:0] i_wb_cmt_target,
  input  logic            i_btb_flush,
  output logic [XLEN-1:0] o_btb_target,
  output logic [2:0]      o_btb_type,
  output logic            o_btb_hit,
  output logic [WB-1:0]   o_btb_way,
  output logic            o_btb_busy
);

  localparam int IDX = $clog2(SETS);
  localparam int PW  = (WAYS > 1) ? WAYS - 1 : 1;
  localparam int TLO = IDX + 2;

  logic [WAYS-1:0]  valid [SETS];
  logic [PW-1:0]    plru  [SETS];
  logic [TAG_W-1:0] tag_q [SETS][WAYS];
  logic [TGT_W-1:0] tgt_q [SETS][WAYS];
  logic [2:0]       typ_q [SETS][WAYS];

  logic           sweep;
  logic [IDX-1:0] sweep_idx;

  // Heap-ordered tree: node n has children 2n and 2n+1; bit points at LRU side.
  function automatic logic [WB-1:0] plru_victim(input logic [PW-1:0] t);
    int n;
    logic [WB-1:0] v;
    n = 1;
    v = '0;
    if (WAYS > 1) begin
      for (int l = 0; l < WB; l++) begin
        v[WB-1-l] = t[n-1];
        n = 2 * n + (t[n-1] ? 1 : 0);
      end
    end
    return v;
  endfunction

  function automatic logic [PW-1:0] plru_touch(
    input logic [PW-1:0] t,
    input logic [WB-1:0] w
  );
    int n;
    logic [PW-1:0] r;
    r = t;
    n = 1;
    if (WAYS > 1) begin
      for (int l = 0; l < WB; l++) begin
        r[n-1] = ~w[WB-1-l];
        n = 2 * n + (w[WB-1-l] ? 1 : 0);
      end
    end
    return r;
  endfunction

`ifdef XCORE_BTB_FLUSH_EN
  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  state_t         state;
  state_t         state_nx;
  logic [IDX-1:0] cnt;

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (state == S_FLUSH) ? cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (i_btb_flush) state_nx = S_FLUSH;
      S_FLUSH: if (cnt == IDX'(SETS - 1)) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    sweep      = (state == S_FLUSH);
    sweep_idx  = cnt;
    o_btb_busy = sweep;
  end
`else
  assign sweep      = 1'b0;
  assign sweep_idx  = '0;
  assign o_btb_busy = 1'b0;
`endif

  logic [IDX-1:0]   l_idx;
  logic [TAG_W-1:0] l_tag;
  logic             l_match;
  logic             l_hit;
  logic [WB-1:0]    l_way;

  assign l_idx = i_pref_pc[IDX+1:2];
  assign l_tag = i_pref_pc[TLO+TAG_W-1:TLO];

  always_comb begin
    l_match = 1'b0;
    l_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid[l_idx][w] && tag_q[l_idx][w] == l_tag) begin
        l_match = 1'b1;
        l_way   = WB'(w);
      end
    end
  end

  assign l_hit = l_match & ~sweep;

  logic             u_wb;
  logic             u_req;
  logic             u_vbit;
  logic [XLEN-1:0]  u_pc;
  logic [XLEN-1:0]  u_tgt;
  logic [2:0]       u_type;
  logic [IDX-1:0]   u_idx;
  logic [TAG_W-1:0] u_tag;

  assign u_wb   = i_wb_cmt_req;
  assign u_req  = (i_wb_cmt_req | i_bpu_btb_update) & ~sweep;
  assign u_vbit = u_wb ? 1'b1 : i_bpu_btb_valid;
  assign u_pc   = u_wb ? i_wb_instr_pc : i_bpu_instr_pc;
  assign u_tgt  = u_wb ? i_wb_cmt_target : i_bpu_btb_target;
  assign u_type = u_wb ? i_wb_cmt_type : i_bpu_btb_type;
  assign u_idx  = u_pc[IDX+1:2];
  assign u_tag  = u_pc[TLO+TAG_W-1:TLO];

  logic          u_match;
  logic [WB-1:0] u_mway;
  logic          u_inv;
  logic [WB-1:0] u_iway;
  logic [WB-1:0] u_way;
  logic          u_we;

  always_comb begin
    u_match = 1'b0;
    u_mway  = '0;
    u_inv   = 1'b0;
    u_iway  = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[u_idx][w]) begin
        u_inv  = 1'b1;
        u_iway = WB'(w);
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (valid[u_idx][w] && tag_q[u_idx][w] == u_tag) begin
        u_match = 1'b1;
        u_mway  = WB'(w);
      end
    end
  end

  assign u_way = u_match ? u_mway :
                 u_inv   ? u_iway : plru_victim(plru[u_idx]);
  assign u_we  = u_req & (u_vbit | u_match);

  // Update touch is issued last so it overrides a lookup touch of the same set.
  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        plru[s]  <= '0;
      end
    end else if (sweep) begin
      valid[sweep_idx] <= '0;
      plru[sweep_idx]  <= '0;
    end else begin
      if (l_hit) plru[l_idx] <= plru_touch(plru[l_idx], l_way);
      if (u_we) begin
        valid[u_idx][u_way] <= u_vbit;
        plru[u_idx]         <= plru_touch(plru[u_idx], u_way);
      end
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst && u_we && u_vbit) begin
      tag_q[u_idx][u_way] <= u_tag;
      tgt_q[u_idx][u_way] <= u_tgt[TGT_W-1:0];
      typ_q[u_idx][u_way] <= u_type;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst) begin
      o_btb_hit    <= 1'b0;
      o_btb_way    <= '0;
      o_btb_type   <= '0;
      o_btb_target <= '0;
    end else begin
      o_btb_hit    <= l_hit;
      o_btb_way    <= l_hit ? l_way : '0;
      o_btb_type   <= l_hit ? typ_q[l_idx][l_way] : 3'b000;
      o_btb_target <= l_hit ?
        {i_pref_pc[XLEN-1:TGT_W], tgt_q[l_idx][l_way]} : '0;
    end
  end

  logic unused;
  assign unused = ^{u_pc[1:0], u_pc[XLEN-1:TLO+TAG_W],
                    u_tgt[XLEN-1:TGT_W], i_pref_pc[1:0], i_btb_flush};

endmodule

// File: tb/tb_xcore_if_btb_sa.sv
// Directed bench for xcore_if_btb_sa: table of lookup/update cycles plus
// hand-written PLRU, flush and reset sequences.
module tb_xcore_if_btb_sa;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pref_pc;
  logic [31:0] bpu_pc;
  logic        bpu_upd;
  logic [2:0]  bpu_type;
  logic [31:0] bpu_tgt;
  logic        bpu_val;
  logic [31:0] wb_pc;
  logic        wb_req;
  logic [2:0]  wb_type;
  logic [31:0] wb_tgt;
  logic        flush;
  logic [31:0] btb_target;
  logic [2:0]  btb_type;
  logic        btb_hit;
  logic [0:0]  btb_way;
  logic        btb_busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  xcore_if_btb_sa dut (
    .i_sys_clk        (clk),
    .i_sys_rst        (rst_n),
    .i_pref_pc        (pref_pc),
    .i_bpu_instr_pc   (bpu_pc),
    .i_bpu_btb_update (bpu_upd),
    .i_bpu_btb_type   (bpu_type),
    .i_bpu_btb_target (bpu_tgt),
    .i_bpu_btb_valid  (bpu_val),
    .i_wb_instr_pc    (wb_pc),
    .i_wb_cmt_req     (wb_req),
    .i_wb_cmt_type    (wb_type),
    .i_wb_cmt_target  (wb_tgt),
    .i_btb_flush      (flush),
    .o_btb_target     (btb_target),
    .o_btb_type       (btb_type),
    .o_btb_hit        (btb_hit),
    .o_btb_way        (btb_way),
    .o_btb_busy       (btb_busy)
  );

  typedef struct {
    logic        wb;
    logic [31:0] wpc;
    logic [31:0] wtg;
    logic [2:0]  wty;
    logic        bu;
    logic [31:0] bpc;
    logic [31:0] btg;
    logic [2:0]  bty;
    logic        bval;
    logic [31:0] lpc;
    logic        ehit;
    logic        eway;
    logic [2:0]  ety;
    logic [31:0] etg;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bpu_upd = 1'b0;
    bpu_pc = '0;
    bpu_tgt = '0;
    bpu_type = '0;
    bpu_val = 1'b0;
    wb_req = 1'b0;
    wb_pc = '0;
    wb_tgt = '0;
    wb_type = '0;
    flush = 1'b0;
    pref_pc = 32'h0000_0008;
  endtask

  task automatic do_reset();
    quiet();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wb_upd(input logic [31:0] pc, input logic [31:0] tg,
                        input logic [2:0] ty);
    wb_req = 1'b1;
    wb_pc = pc;
    wb_tgt = tg;
    wb_type = ty;
    step();
    quiet();
  endtask

  task automatic look(input string nm, input logic [31:0] pc,
                      input logic ehit);
    pref_pc = pc;
    step();
    chk(nm, 32'(btb_hit), 32'(ehit));
    pref_pc = 32'h0000_0008;
  endtask

  task automatic look_way(input string nm, input logic [31:0] pc,
                          input logic eway);
    pref_pc = pc;
    step();
    chk(nm, {btb_hit, btb_way}, {1'b1, eway});
    pref_pc = 32'h0000_0008;
  endtask

  initial begin
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1000, 0, 0, 0, 0};
    tbl[1]  = '{1, 32'h1000, 32'h2040, 3'b010, 0, 0, 0, 0, 0,
                32'h1000, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,
                32'h1000, 1, 0, 3'b010, 32'h2040};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,
                32'h0100_1000, 1, 0, 3'b010, 32'h0100_2040};
    tbl[4]  = '{1, 32'h200, 32'h300, 3'b100, 1, 32'h200, 32'h400, 3'b001, 1,
                32'h200, 0, 0, 0, 0};
    tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,
                32'h200, 1, 1, 3'b100, 32'h300};
    tbl[6]  = '{0, 0, 0, 0, 1, 32'h5000, 0, 0, 0,
                32'h1000, 1, 0, 3'b010, 32'h2040};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,
                32'h200, 1, 1, 3'b100, 32'h300};
    tbl[8]  = '{0, 0, 0, 0, 1, 32'h1000, 0, 0, 0,
                32'h200, 1, 1, 3'b100, 32'h300};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1000, 0, 0, 0, 0};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,
                32'h200, 1, 1, 3'b100, 32'h300};
    tbl[11] = '{0, 0, 0, 0, 1, 32'h104, 32'habc, 3'b001, 1,
                32'h104, 0, 0, 0, 0};
    tbl[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,
                32'h104, 1, 0, 3'b001, 32'habc};
    tbl[13] = '{1, 32'h1000, 32'h2040, 3'b010, 0, 0, 0, 0, 0,
                32'h1000, 0, 0, 0, 0};
    tbl[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,
                32'h1000, 1, 0, 3'b010, 32'h2040};

    do_reset();
    chk("rst_hit", 32'(btb_hit), 0);
    chk("rst_way", 32'(btb_way), 0);
    chk("rst_type", 32'(btb_type), 0);
    chk("rst_target", btb_target, 0);
    chk("rst_busy", 32'(btb_busy), 0);

    for (int i = 0; i < 15; i++) begin
      wb_req = tbl[i].wb;
      wb_pc = tbl[i].wpc;
      wb_tgt = tbl[i].wtg;
      wb_type = tbl[i].wty;
      bpu_upd = tbl[i].bu;
      bpu_pc = tbl[i].bpc;
      bpu_tgt = tbl[i].btg;
      bpu_type = tbl[i].bty;
      bpu_val = tbl[i].bval;
      pref_pc = tbl[i].lpc;
      step();
      chk($sformatf("v%0d_hit", i), 32'(btb_hit), 32'(tbl[i].ehit));
      chk($sformatf("v%0d_way", i), 32'(btb_way), 32'(tbl[i].eway));
      chk($sformatf("v%0d_type", i), 32'(btb_type), 32'(tbl[i].ety));
      chk($sformatf("v%0d_tgt", i), btb_target, tbl[i].etg);
    end
    quiet();

    // PLRU: no lookups between fills, oldest way is replaced
    do_reset();
    wb_upd(32'h0100, 32'h0111, 3'b100);
    wb_upd(32'h1100, 32'h0222, 3'b100);
    wb_upd(32'h2100, 32'h0333, 3'b100);
    look("plru1_0100", 32'h0100, 1'b0);
    look_way("plru1_1100", 32'h1100, 1'b1);
    look_way("plru1_2100", 32'h2100, 1'b0);

    // PLRU: a hit on 0x0100 steers the victim to 0x1100
    do_reset();
    wb_upd(32'h0100, 32'h0111, 3'b100);
    wb_upd(32'h1100, 32'h0222, 3'b100);
    look_way("plru2_touch", 32'h0100, 1'b0);
    wb_upd(32'h2100, 32'h0333, 3'b100);
    look("plru2_1100", 32'h1100, 1'b0);
    look_way("plru2_0100", 32'h0100, 1'b0);
    look_way("plru2_2100", 32'h2100, 1'b1);

    do_reset();
    for (int k = 0; k < 8; k++)
      wb_upd(32'h1000 + 32'(4 * k), 32'h2000 + 32'(k), 3'b001);
    look("fill_hit", 32'h1008, 1'b1);

`ifdef XCORE_BTB_FLUSH_EN
    begin
      int n;
      int hits;
      flush = 1'b1;
      step();
      flush = 1'b0;
      n = 0;
      hits = 0;
      while (btb_busy && n < 200) begin
        n++;
        pref_pc = 32'h1000;
        wb_req = 1'b1;
        wb_pc = 32'h3000;
        wb_tgt = 32'h3333;
        wb_type = 3'b010;
        step();
        if (btb_hit) hits++;
      end
      quiet();
      chk("flush_busy_cycles", 32'(n), 64);
      chk("flush_hits_during", 32'(hits), 0);
      chk("flush_busy_end", 32'(btb_busy), 0);
      for (int k = 0; k < 8; k++)
        look($sformatf("flush_miss%0d", k), 32'h1000 + 32'(4 * k), 1'b0);
      look("flush_dropped_upd", 32'h3000, 1'b0);
    end

    for (int k = 0; k < 8; k++)
      wb_upd(32'h1000 + 32'(4 * k), 32'h2000 + 32'(k), 3'b001);
    look("refill_hit", 32'h101c, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int c = 0; c < 10; c++) step();
    chk("abort_busy_before", 32'(btb_busy), 1);
    rst_n = 1'b0;
    step();
    chk("abort_busy_after", 32'(btb_busy), 0);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++)
      look($sformatf("abort_miss%0d", k), 32'h1000 + 32'(4 * k), 1'b0);
    chk("abort_busy_idle", 32'(btb_busy), 0);
`else
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("noflush_busy", 32'(btb_busy), 0);
    step();
    chk("noflush_busy2", 32'(btb_busy), 0);
    for (int k = 0; k < 8; k++)
      look($sformatf("noflush_hit%0d", k), 32'h1000 + 32'(4 * k), 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
